// File: rtl/div_32_bit_seq_if.sv
// Request/response bundle between the multdiv issue logic and the sequential divider.
interface div_32_bit_seq_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_32_bit_seq.sv
// Restoring signed divider, one quotient bit per cycle. Trial subtract is
// R_shifted + ~D + 1 through a chain of 8-bit carry-lookahead adders.
module cla_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] p, g;
  logic [8:0] c;
  logic       term, prod;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is expanded in terms of cin and the g/p terms below it.
  always_comb begin
    c    = '0;
    term = 1'b0;
    prod = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      term = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = term | (prod & cin);
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];
endmodule

module div_32_bit_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  div_32_bit_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int NB = WIDTH / 8;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_quo_q, sgn_quo_d;
  logic             sgn_rem_q, sgn_rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  // Datapath for one restoring step
  logic [WIDTH-1:0] r_sh, q_sh, sub_b, sub_sum, r_step, q_step;
  logic [NB:0]      carry;
  logic             no_borrow;

  assign r_sh  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign q_sh  = {q_q[WIDTH-2:0], 1'b0};
  assign sub_b = ~dvs_q;
  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < NB; gi++) begin : g_cla
    cla_8_bit u_cla (
      .a    (r_sh[gi*8 +: 8]),
      .b    (sub_b[gi*8 +: 8]),
      .cin  (carry[gi]),
      .sum  (sub_sum[gi*8 +: 8]),
      .cout (carry[gi+1])
    );
  end

  // 33rd bit: the bit shifted out of R always covers the divisor.
  assign no_borrow = r_q[WIDTH-1] | carry[NB];
  assign r_step    = no_borrow ? sub_sum : r_sh;
  assign q_step    = {q_sh[WIDTH-1:1], no_borrow};

  logic [WIDTH-1:0] abs_a, abs_b;
  logic             op_err;

  assign abs_a  = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign abs_b  = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign op_err = (bus.data_operandB == '0) ||
                  (bus.data_operandA == MIN_NEG && bus.data_operandB == '1);

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    result_d  = result_q;
    rem_d     = rem_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    // A start in any state (re)captures operands, aborting work in flight.
    if (bus.ctrl_DIV) begin
      sgn_quo_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      sgn_rem_d = bus.data_operandA[WIDTH-1];
      q_d       = abs_a;
      dvs_d     = abs_b;
      r_d       = '0;
      cnt_d     = '0;
      if (op_err) begin
        state_d  = DONE;
        result_d = '0;
        rem_d    = '0;
        exc_d    = 1'b1;
        rdy_d    = 1'b1;
      end else begin
        state_d  = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          r_d   = r_step;
          q_d   = q_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = sgn_quo_q ? -q_step : q_step;
            rem_d    = sgn_rem_q ? -r_step : r_step;
            exc_d    = 1'b0;
            rdy_d    = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      q_q       <= '0;
      dvs_q     <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      result_q  <= '0;
      rem_q     <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      dvs_q     <= dvs_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      result_q  <= result_d;
      rem_q     <= rem_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_remainder = rem_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_div_32_bit_seq.sv
// Scoreboard bench for div_32_bit_seq: stimulus pushes expected responses,
// a negedge monitor pops and checks them whenever data_resultRDY is seen.
module tb_div_32_bit_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  div_32_bit_seq_if #(.WIDTH(32)) bus ();

  div_32_bit_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    int          rdy_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed / and % truncate toward zero with remainder taking the dividend's sign.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb_, quo, rm;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    e.rdy_cyc = 0;
    if (sb_ == 0 || (sa == -64'sd2147483648 && sb_ == -1)) begin
      e.res = '0; e.rem = '0; e.exc = 1'b1;
    end else begin
      quo = sa / sb_;
      rm  = sa % sb_;
      e.res = quo[31:0]; e.rem = rm[31:0]; e.exc = 1'b0;
    end
    return e;
  endfunction

  // Called just after a rising edge; the pulse is sampled on the following edge (E0).
  task automatic start(input logic [31:0] a, input logic [31:0] b, input bit abort);
    exp_t e;
    e = model(a, b);
    e.rdy_cyc = cyc + 1 + (e.exc ? 0 : 32);
    if (abort && sb.size() > 0) void'(sb.pop_back());
    sb.push_back(e);
    last_exp = e;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_DIV = 1'b1;
    @(posedge clock); #1;
    bus.ctrl_DIV = 1'b0;
    chk("busy_after_start", {31'b0, bus.busy}, {31'b0, ~e.exc});
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clock);
    #1;
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: %0d results still pending at cycle %0d", sb.size(), cyc);
      sb.delete();
    end else begin
      chk("busy_idle", {31'b0, bus.busy}, 32'd0);
      chk("hold_result", bus.data_result, last_exp.res);
      chk("hold_rem", bus.data_remainder, last_exp.rem);
    end
  endtask

  task automatic wait_cycle(input int target);
    for (int k = 0; k < 100 && cyc < target; k++) @(posedge clock);
    #1;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    start(a, b, 1'b0);
    wait_done();
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (bus.data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_ready: data_resultRDY=1 with nothing pending at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("ready_cycle", cyc, e.rdy_cyc);
        chk("result", bus.data_result, e.res);
        chk("remainder", bus.data_remainder, e.rem);
        chk("exception", {31'b0, bus.data_exception}, {31'b0, e.exc});
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    exp_t e;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    last_exp = '{res: 32'd0, rem: 32'd0, exc: 1'b0, rdy_cyc: 0};
    repeat (3) @(posedge clock);
    #1;
    chk("rst_result", bus.data_result, 32'd0);
    chk("rst_rem", bus.data_remainder, 32'd0);
    chk("rst_exc", {31'b0, bus.data_exception}, 32'd0);
    chk("rst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run(32'd100, 32'd7);
    run(32'hFFFFFF9C, 32'd7);
    run(32'd100, 32'hFFFFFFF9);
    run(32'd5, 32'd0);
    run(32'h80000000, 32'hFFFFFFFF);
    run(32'h80000000, 32'd2);
    run(32'h7FFFFFFF, 32'd1);
    run(32'd3, 32'd10);
    run(32'd0, 32'hFFFFFFF7);
    run(32'h80000000, 32'h80000000);
    run(32'hFFFFFFFF, 32'h80000000);

    // Abort: second pulse mid-run replaces the pending result.
    start(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    start(32'd81, 32'd9, 1'b1);
    wait_done();

    // Back-to-back: next start sampled while in DONE.
    start(32'd1000, 32'd33, 1'b0);
    e = sb[sb.size()-1];
    wait_cycle(e.rdy_cyc);
    start(32'hFFFFFC18, 32'd33, 1'b0);
    wait_done();

    // Reset mid-divide drops the operation.
    start(32'd100, 32'd7, 1'b0);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_result", bus.data_result, 32'd0);
    chk("midrst_rem", bus.data_remainder, 32'd0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run(32'd81, 32'd9);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
      if (rb == 32'd0 || (ra == 32'h80000000 && rb == 32'hFFFFFFFF)) rb = 32'd3;
      if (i % 3 == 0 && sb.size() != 0) begin
        e = sb[sb.size()-1];
        wait_cycle(e.rdy_cyc);
        start(ra, rb, 1'b0);
      end else begin
        wait_done();
        start(ra, rb, 1'b0);
      end
    end
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/div_32_bit_seq.md
# div_32_bit_seq

Multi-cycle 32-bit signed integer divider for the processor's multdiv path. It is the subtract-direction counterpart of the adder datapath. It produces quotient and remainder by restoring division, one bit per cycle. Each trial subtraction is A + ~B + 1 through four chained cla_8_bit adders. The block sits beside the ALU; the pipeline stalls on ctrl_DIV until data_resultRDY.

## Interface
- WIDTH, 32: operand/result width. Only 32 is required to work; the iteration counter is sized from it.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- ctrl_DIV  in  1  start pulse; operands are sampled on the same edge.
- data_operandA  in  32  dividend, two's complement.
- data_operandB  in  32  divisor, two's complement.
- data_result  out  32  quotient, registered.
- data_remainder  out  32  remainder, registered.
- data_exception  out  1  error flag; valid when data_resultRDY=1.
- data_resultRDY  out  1  one-cycle done pulse.
- busy  out  1  high in RUN state.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE. All outputs reset to 0.
- IDLE, ctrl_DIV=1 at edge:
  - Capture sign_q = A[31]^B[31] and sign_r = A[31].
  - Load dividend register Q = |A|, divisor register D = |B|, partial remainder R = 0, count = 0.
  - Go to RUN.
- Magnitudes are unsigned 32-bit, so |0x80000000| = 0x80000000.
- Error check at capture: B==0, or A==0x80000000 with B==0xFFFFFFFF. Either one skips RUN and goes straight to DONE with data_result=0, data_remainder=0, data_exception=1.
- RUN, each edge:
  - Shift {R,Q} left 1 and form T = R_shifted − D as a 33-bit subtract (carry-out = no borrow).
  - No borrow: R = T and Q[0] = 1.
  - Borrow: R = R_shifted and Q[0] = 0.
  - count increments. The edge with count==31 writes the last bit and moves to DONE.
- Entering DONE registers the outputs:
  - data_result = sign_q ? −Q : Q.
  - data_remainder = sign_r ? −R : R.
  - data_exception = 0.
- Rounding: quotient truncates toward zero; remainder takes the sign of the dividend.
- DONE: data_resultRDY=1 for exactly one cycle, then go to IDLE on the next edge.
- data_result, data_remainder and data_exception hold until the next DONE entry or reset.
- ctrl_DIV during RUN or DONE aborts the current operation and restarts from the new operands, the same as the IDLE capture. The aborted operation never raises data_resultRDY.
- Reset mid-RUN: immediate return to IDLE, all outputs 0, no data_resultRDY.

## Timing
- ctrl_DIV is sampled at edge E0. busy goes high after E0.
- RUN occupies the 32 edges E1..E32. DONE is entered at E32, so data_resultRDY is high between E32 and E33. Normal latency is 32 cycles, start edge to ready.
- Error case: DONE is entered at E0 itself, and data_resultRDY is high between E0 and E1.
- Back-to-back: ctrl_DIV sampled during DONE (at E33) starts the next divide. IDLE is skipped.
- No combinational path from inputs to outputs.
- Critical path: one 32-bit CLA subtract plus a 2:1 mux per cycle.

## Test plan
- A=100, B=7, ctrl_DIV pulse -> at cycle 32: data_result=14, data_remainder=2, data_exception=0, data_resultRDY high exactly 1 cycle.
- A=−100 (0xFFFFFF9C), B=7 -> data_result=−14 (0xFFFFFFF2), data_remainder=−2. Also A=100, B=−7 -> −14 and 2.
- A=5, B=0 -> data_resultRDY the cycle after start, data_exception=1, outputs 0. Also A=0x80000000, B=−1 -> same exception response.
- Edges: A=0x80000000, B=2 -> 0xC0000000 r0. A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF r0. A=3, B=10 -> 0 r3. A=0, B=−9 -> 0 r0.
- Restart: start 100/7, re-pulse ctrl_DIV with 81/9 at cycle 10 -> no ready at the original cycle 32; ready 32 cycles after the second pulse with 9 r0.
- Reset: assert reset at cycle 15 of a divide -> outputs 0 and busy 0 immediately, no data_resultRDY. A new start after release completes normally. Finish with a 1000-vector random signed regression against a reference model, excluding the two exception cases.
